// File: rtl/dma_write_status_gen.sv
// dma_write_status_gen: counts bytes written per descriptor and pushes one status word per completed descriptor.
// Ports: clk/reset_n (async active-low reset); chain_start_i restarts the index and aborts any descriptor in flight;
// desc_start_i/desc_length_i/desc_last_i/desc_ready_o form the descriptor handshake; wr_beat_i/wr_be_i/wr_eop_i
// report accepted AVMM write beats; dma_status_fifo_* is the status FIFO write side;
// status_push_count_o is a wrapping count of status words pushed.
module dma_write_status_gen #(
  parameter int BE_WIDTH  = 4,
  parameter int MAX_INDEX = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chain_start_i,
  input  logic                desc_start_i,
  input  logic [15:0]         desc_length_i,
  input  logic                desc_last_i,
  output logic                desc_ready_o,
  input  logic                wr_beat_i,
  input  logic [BE_WIDTH-1:0] wr_be_i,
  input  logic                wr_eop_i,
  input  logic                dma_status_fifo_almost_full_i,
  output logic                dma_status_fifo_wr_req_o,
  output logic [24:0]         dma_status_fifo_data_o,
  output logic [15:0]         status_push_count_o
);
  typedef enum logic [1:0] {IDLE, ACTIVE, PUSH} state_t;
  state_t state_q, state_d;
  logic [15:0] len_q, count_q, count_nx;
  logic [7:0]  index_q;
  logic        last_q, accept, beat_en, push, abort, reached;
  logic [16:0] pop, sum;
  always_comb begin
    pop = '0;
    for (int i = 0; i < BE_WIDTH; i++) pop = pop + 17'(wr_be_i[i]);
  end
  // 17-bit sum so the clamp comparison sees carries; the stored count never exceeds the length
  assign sum          = {1'b0, count_q} + pop;
  assign reached      = sum >= {1'b0, len_q};
  assign count_nx     = reached ? len_q : sum[15:0];
  assign abort        = chain_start_i && state_q != IDLE;
  assign desc_ready_o = state_q == IDLE;
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    beat_en = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        accept = desc_start_i;
        if (desc_start_i) state_d = desc_length_i == '0 ? PUSH : ACTIVE;
      end
      ACTIVE: begin
        beat_en = wr_beat_i && !chain_start_i;
        if (chain_start_i) state_d = IDLE;
        else if (wr_beat_i && (reached || wr_eop_i)) state_d = PUSH;
      end
      PUSH: begin
        push = !chain_start_i && !dma_status_fifo_almost_full_i;
        if (chain_start_i || !dma_status_fifo_almost_full_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q                  <= IDLE;
      len_q                    <= '0;
      last_q                   <= 1'b0;
      count_q                  <= '0;
      index_q                  <= '0;
      dma_status_fifo_wr_req_o <= 1'b0;
      dma_status_fifo_data_o   <= '0;
      status_push_count_o      <= '0;
    end else begin
      state_q                  <= state_d;
      dma_status_fifo_wr_req_o <= push;
      if (push) begin
        dma_status_fifo_data_o <= {last_q, index_q, count_q};
        status_push_count_o    <= status_push_count_o + 16'd1;
      end
      if (chain_start_i) index_q <= '0;
      else if (push) index_q <= index_q == 8'(MAX_INDEX) ? '0 : index_q + 8'd1;
      if (accept) begin
        len_q   <= desc_length_i;
        last_q  <= desc_last_i;
        count_q <= '0;
      end else if (abort) count_q <= '0;
      else if (beat_en) count_q <= count_nx;
    end
  end
endmodule

// File: tb/tb_dma_write_status_gen.sv
// tb_dma_write_status_gen: randomized descriptors checked against a transaction-level status model.
module tb_dma_write_status_gen;
  localparam int MAXI = 3;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        chain_start = 1'b0, desc_start = 1'b0, desc_last = 1'b0;
  logic [15:0] desc_length = '0;
  logic        desc_ready, wr_beat = 1'b0, wr_eop = 1'b0, af = 1'b0, wr_req;
  logic [3:0]  wr_be = '0;
  logic [24:0] data;
  logic [15:0] push_count;
  int n_checks = 0, n_errors = 0, model_idx = 0, model_pushes = 0;

  dma_write_status_gen #(.BE_WIDTH(4), .MAX_INDEX(MAXI)) dut (
    .clk(clk), .reset_n(reset_n), .chain_start_i(chain_start), .desc_start_i(desc_start),
    .desc_length_i(desc_length), .desc_last_i(desc_last), .desc_ready_o(desc_ready),
    .wr_beat_i(wr_beat), .wr_be_i(wr_be), .wr_eop_i(wr_eop),
    .dma_status_fifo_almost_full_i(af), .dma_status_fifo_wr_req_o(wr_req),
    .dma_status_fifo_data_o(data), .status_push_count_o(push_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // fbe!=0 forces every byte-enable; eop_beat>0 ends on that beat, <0 ends randomly
  task automatic run_desc(input int len, input bit last, input bit chain, input int af_hold,
                          input logic [3:0] fbe, input int eop_beat);
    int bytes, beats, lat, exp_bytes;
    bit done, eop;
    logic [3:0] be;
    logic [31:0] exp_data;
    bytes = 0;
    beats = 0;
    done = (len == 0);
    check("ready_idle", 32'(desc_ready), 1);
    desc_start = 1'b1;
    desc_length = 16'(len);
    desc_last = last;
    chain_start = chain;
    af = af_hold > 0;
    wr_beat = 1'($urandom);
    wr_be = 4'($urandom);
    if (chain) model_idx = 0;
    step();
    desc_start = 1'b0;
    chain_start = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if ($urandom_range(3) == 0) begin
        wr_beat = 1'b0;
        wr_be = 4'($urandom);
        wr_eop = 1'($urandom);
      end else begin
        be = fbe != 0 ? fbe : 4'($urandom);
        beats++;
        bytes += $countones(be);
        eop = eop_beat > 0 ? beats == eop_beat : (eop_beat < 0 && $urandom_range(4) == 0);
        wr_beat = 1'b1;
        wr_be = be;
        wr_eop = eop;
        done = bytes >= len || eop;
      end
      step();
    end
    check("desc_done", 32'(done), 1);
    wr_beat = 1'($urandom);
    wr_be = 4'($urandom);
    wr_eop = 1'($urandom);
    exp_bytes = bytes < len ? bytes : len;
    exp_data = {7'b0, last, 8'(model_idx), 16'(exp_bytes)};
    for (int i = 0; i < af_hold; i++) begin
      check("hold_no_req", 32'(wr_req), 0);
      check("hold_not_ready", 32'(desc_ready), 0);
      desc_start = 1'($urandom);
      desc_length = 16'($urandom);
      step();
    end
    desc_start = 1'b0;
    af = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!wr_req && lat < 8);
    check("latency", 32'(lat), 1);
    check("status_data", 32'(data), exp_data);
    model_idx = model_idx == MAXI ? 0 : model_idx + 1;
    model_pushes++;
    check("push_count", 32'(push_count), 32'(model_pushes & 16'hffff));
    step();
    check("one_shot", 32'(wr_req), 0);
    check("ready_after", 32'(desc_ready), 1);
    check("data_hold", 32'(data), exp_data);
  endtask

  task automatic run_abort(input bit in_push);
    desc_start = 1'b1;
    desc_length = in_push ? 16'd4 : 16'd100;
    desc_last = 1'b0;
    af = in_push;
    wr_beat = 1'b0;
    step();
    desc_start = 1'b0;
    wr_beat = 1'b1;
    wr_be = 4'hF;
    wr_eop = 1'b0;
    step();
    wr_beat = 1'b0;
    check("busy_not_ready", 32'(desc_ready), 0);
    chain_start = 1'b1;
    step();
    chain_start = 1'b0;
    af = 1'b0;
    model_idx = 0;
    for (int i = 0; i < 5; i++) begin
      check("abort_no_req", 32'(wr_req), 0);
      step();
    end
    check("abort_ready", 32'(desc_ready), 1);
    check("abort_push_count", 32'(push_count), 32'(model_pushes));
  endtask

  initial begin
    step();
    step();
    check("rst_req", 32'(wr_req), 0);
    check("rst_data", 32'(data), 0);
    check("rst_count", 32'(push_count), 0);
    check("rst_ready", 32'(desc_ready), 1);
    reset_n = 1'b1;
    step();
    run_desc(8, 0, 0, 0, 4'hF, 0);
    run_desc(6, 1, 0, 0, 4'hF, 0);
    run_desc(16, 0, 0, 0, 4'hF, 2);
    run_desc(4, 0, 0, 10, 4'hF, 0);
    run_desc(0, 0, 0, 0, 4'h0, 0);
    run_desc(5, 1, 0, 0, 4'hF, 0);
    run_abort(1'b0);
    run_desc(3, 0, 0, 0, 4'h0, 0);
    run_abort(1'b1);
    run_desc(9, 1, 0, 0, 4'h0, 0);
    run_desc(7, 0, 1, 0, 4'h0, 0);
    for (int k = 0; k < 40; k++)
      run_desc($urandom_range(40), 1'($urandom), $urandom_range(7) == 0,
               $urandom_range(3), 4'h0, $urandom_range(1) ? -1 : 0);
    desc_start = 1'b1;
    desc_length = 16'd4;
    af = 1'b1;
    wr_beat = 1'b0;
    step();
    desc_start = 1'b0;
    wr_beat = 1'b1;
    wr_be = 4'hF;
    step();
    wr_beat = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(wr_req), 0);
    check("mid_rst_data", 32'(data), 0);
    check("mid_rst_count", 32'(push_count), 0);
    check("mid_rst_ready", 32'(desc_ready), 1);
    step();
    reset_n = 1'b1;
    af = 1'b0;
    model_idx = 0;
    model_pushes = 0;
    step();
    check("post_rst_no_req", 32'(wr_req), 0);
    run_desc(12, 1, 0, 0, 4'h0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
